// File: rtl/fifo_mem_ctrl_if.sv
// Bundle between the FIFO sequencer, its producer/consumer and the 8x10 memory.
// The slave view belongs to the sequencer; the master view to its environment.
interface fifo_mem_ctrl_if #(
    parameter int RAM_WIDTH = 10,
    parameter int ADDR_SIZE = 3
);
    logic                 push;
    logic [RAM_WIDTH-1:0] data_in;
    logic                 pop;
    logic [ADDR_SIZE:0]   umbral_af;
    logic [ADDR_SIZE:0]   umbral_ae;
    logic                 mem_wr_enb;
    logic [ADDR_SIZE-1:0] mem_wr_addr;
    logic [RAM_WIDTH-1:0] mem_data_in;
    logic                 mem_rd_enb;
    logic [ADDR_SIZE-1:0] mem_rd_addr;
    logic [RAM_WIDTH-1:0] mem_data_out;
    logic [RAM_WIDTH-1:0] data_out;
    logic                 valid;
    logic [ADDR_SIZE:0]   fifo_count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 err_overflow;
    logic                 err_underflow;

    modport slave (
        input  push, data_in, pop, umbral_af, umbral_ae, mem_data_out,
        output mem_wr_enb, mem_wr_addr, mem_data_in,
        output mem_rd_enb, mem_rd_addr,
        output data_out, valid, fifo_count, full, empty,
        output almost_full, almost_empty, err_overflow, err_underflow
    );

    modport master (
        output push, data_in, pop, umbral_af, umbral_ae, mem_data_out,
        input  mem_wr_enb, mem_wr_addr, mem_data_in,
        input  mem_rd_enb, mem_rd_addr,
        input  data_out, valid, fifo_count, full, empty,
        input  almost_full, almost_empty, err_overflow, err_underflow
    );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// FIFO sequencer for an external 8x10 dual-port memory.
// Turns push/pop requests into memory strobes and tracks occupancy/status.
module fifo_mem_ctrl #(
    parameter int RAM_WIDTH = 10,
    parameter int RAM_DEPTH = 8,
    parameter int ADDR_SIZE = 3
) (
    input  logic          clk,
    input  logic          rst,
    fifo_mem_ctrl_if.slave ctrl_io
);
    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(RAM_DEPTH);
    localparam logic [ADDR_SIZE:0] ONE   = (ADDR_SIZE+1)'(1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ACTIVE,
        S_FULL
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 full, empty;
    logic                 push_ok, pop_ok;

    // Accept/reject decisions, pointer/count updates and next state.
    always_comb begin
        full     = (state_q == S_FULL);
        empty    = (state_q == S_EMPTY);
        pop_ok   = ctrl_io.pop & ~empty & ~rst;
        push_ok  = ctrl_io.push & (~full | pop_ok) & ~rst;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        valid_d  = pop_ok;
        ovf_d    = ovf_q | (ctrl_io.push & full & ~pop_ok);
        udf_d    = udf_q | (ctrl_io.pop & empty);
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        unique case (state_q)
            S_EMPTY: begin
                if (push_ok) state_d = (DEPTH == ONE) ? S_FULL : S_ACTIVE;
            end
            S_ACTIVE: begin
                if (push_ok && !pop_ok && count_q == DEPTH - ONE)
                    state_d = S_FULL;
                else if (pop_ok && !push_ok && count_q == ONE)
                    state_d = S_EMPTY;
            end
            S_FULL: begin
                if (pop_ok && !push_ok)
                    state_d = (DEPTH == ONE) ? S_EMPTY : S_ACTIVE;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State registers; memory contents live outside and are untouched by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Memory strobes follow the current request and pointers.
    always_comb begin
        ctrl_io.mem_wr_enb  = push_ok;
        ctrl_io.mem_wr_addr = wr_ptr_q;
        ctrl_io.mem_data_in = ctrl_io.data_in;
        ctrl_io.mem_rd_enb  = pop_ok;
        ctrl_io.mem_rd_addr = rd_ptr_q;
    end

    // Status decodes; read data is the memory's registered output.
    always_comb begin
        ctrl_io.valid         = valid_q;
        ctrl_io.data_out      = valid_q ? ctrl_io.mem_data_out : '0;
        ctrl_io.fifo_count    = count_q;
        ctrl_io.full          = full;
        ctrl_io.empty         = empty;
        ctrl_io.almost_full   = (count_q >= ctrl_io.umbral_af);
        ctrl_io.almost_empty  = (count_q <= ctrl_io.umbral_ae);
        ctrl_io.err_overflow  = ovf_q;
        ctrl_io.err_underflow = udf_q;
    end
endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl: memory stand-in, queue model checked each cycle,
// and directed sequences with hand-computed expectations.
module tb_fifo_mem_ctrl;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fifo_mem_ctrl_if #(.RAM_WIDTH(10), .ADDR_SIZE(3)) bus ();

    fifo_mem_ctrl #(
        .RAM_WIDTH(10),
        .RAM_DEPTH(8),
        .ADDR_SIZE(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory stand-in: synchronous write, registered read.
    logic [9:0] mem [8];
    logic [9:0] mem_rd = '0;
    always @(posedge clk) begin
        if (bus.mem_wr_enb) mem[bus.mem_wr_addr] <= bus.mem_data_in;
        if (bus.mem_rd_enb) mem_rd <= mem[bus.mem_rd_addr];
    end
    assign bus.mem_data_out = mem_rd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: a queue of stored words plus running op counts.
    logic [9:0] mq[$];
    int         wp = 0;
    int         rp = 0;
    bit         ev = 0;
    logic [9:0] edout = '0;
    bit         eovf = 0;
    bit         eudf = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            begin
                int cnt;
                bit m_full, m_empty, pok, wok;
                cnt     = mq.size();
                m_full  = (cnt == 8);
                m_empty = (cnt == 0);
                pok     = bus.pop && !m_empty && !rst;
                wok     = bus.push && (!m_full || pok) && !rst;
                chk("count", 32'(bus.fifo_count), 32'(cnt));
                chk("full", 32'(bus.full), 32'(m_full));
                chk("empty", 32'(bus.empty), 32'(m_empty));
                chk("afull", 32'(bus.almost_full),
                    32'(cnt >= int'(bus.umbral_af)));
                chk("aempty", 32'(bus.almost_empty),
                    32'(cnt <= int'(bus.umbral_ae)));
                chk("valid", 32'(bus.valid), 32'(ev));
                if (ev) chk("dout", 32'(bus.data_out), 32'(edout));
                chk("ovf", 32'(bus.err_overflow), 32'(eovf));
                chk("udf", 32'(bus.err_underflow), 32'(eudf));
                chk("wr_enb", 32'(bus.mem_wr_enb), 32'(wok));
                chk("rd_enb", 32'(bus.mem_rd_enb), 32'(pok));
                if (wok) begin
                    chk("wr_addr", 32'(bus.mem_wr_addr), 32'(wp));
                    chk("wr_data", 32'(bus.mem_data_in), 32'(bus.data_in));
                end
                if (pok) chk("rd_addr", 32'(bus.mem_rd_addr), 32'(rp));
                if (rst) begin
                    mq.delete();
                    wp = 0; rp = 0; ev = 0; eovf = 0; eudf = 0;
                end else begin
                    if (bus.push && m_full && !pok) eovf = 1;
                    if (bus.pop && m_empty) eudf = 1;
                    ev = pok;
                    if (pok) begin
                        edout = mq.pop_front();
                        rp = (rp + 1) % 8;
                    end
                    if (wok) begin
                        mq.push_back(bus.data_in);
                        wp = (wp + 1) % 8;
                    end
                end
            end
        end
    end

    task automatic cyc(input bit r, input bit p, input logic [9:0] d,
                       input bit q);
        @(posedge clk);
        #1;
        rst      = r;
        bus.push = p;
        bus.data_in = d;
        bus.pop  = q;
    endtask

    initial begin
        rst = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = '0;
        bus.umbral_af = 4'd6;
        bus.umbral_ae = 4'd1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(bus.fifo_count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_dout", 32'(bus.data_out), 0);
        chk("rst_wr", 32'(bus.mem_wr_enb), 0);
        chk("rst_rd", 32'(bus.mem_rd_enb), 0);
        chk("rst_ovf", 32'(bus.err_overflow), 0);
        chk("rst_udf", 32'(bus.err_underflow), 0);

        cyc(0, 1, 10'h0CC, 0);
        @(negedge clk);
        chk("p1_wen", 32'(bus.mem_wr_enb), 1);
        chk("p1_wad", 32'(bus.mem_wr_addr), 0);
        cyc(0, 0, 0, 1);
        @(negedge clk);
        chk("p1_cnt", 32'(bus.fifo_count), 1);
        chk("p1_rad", 32'(bus.mem_rd_addr), 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("p1_valid", 32'(bus.valid), 1);
        chk("p1_dout", 32'(bus.data_out), 32'h0CC);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("p1_pulse", 32'(bus.valid), 0);

        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) cyc(0, 1, 10'(i), 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("f_full", 32'(bus.full), 1);
        chk("f_cnt", 32'(bus.fifo_count), 8);
        chk("f_afull", 32'(bus.almost_full), 1);
        cyc(0, 1, 10'h3AA, 0);
        @(negedge clk);
        chk("f_nowr", 32'(bus.mem_wr_enb), 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("f_ovf", 32'(bus.err_overflow), 1);
        cyc(0, 1, 10'h3FF, 1);
        @(negedge clk);
        chk("fb_wen", 32'(bus.mem_wr_enb), 1);
        chk("fb_wad", 32'(bus.mem_wr_addr), 0);
        chk("fb_ren", 32'(bus.mem_rd_enb), 1);
        chk("fb_rad", 32'(bus.mem_rd_addr), 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("fb_cnt", 32'(bus.fifo_count), 8);
        chk("fb_valid", 32'(bus.valid), 1);
        chk("fb_dout", 32'(bus.data_out), 32'h001);

        repeat (8) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("d_empty", 32'(bus.empty), 1);
        chk("d_dout", 32'(bus.data_out), 32'h3FF);
        cyc(0, 0, 0, 1);
        @(negedge clk);
        chk("u_nord", 32'(bus.mem_rd_enb), 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("u_udf", 32'(bus.err_underflow), 1);
        chk("u_valid", 32'(bus.valid), 0);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 10'h055, 1);
        @(negedge clk);
        chk("ub_wen", 32'(bus.mem_wr_enb), 1);
        chk("ub_ren", 32'(bus.mem_rd_enb), 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("ub_cnt", 32'(bus.fifo_count), 1);
        chk("ub_udf", 32'(bus.err_underflow), 1);
        chk("ub_valid", 32'(bus.valid), 0);
        chk("ub_aempty", 32'(bus.almost_empty), 1);

        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 10'h100 + 10'(i), 0);
            if (i == 2) begin
                @(negedge clk);
                chk("t_ae_c2", 32'(bus.almost_empty), 0);
            end
            if (i == 5) begin
                @(negedge clk);
                chk("t_af_c5", 32'(bus.almost_full), 0);
            end
        end
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("t_cnt6", 32'(bus.fifo_count), 6);
        chk("t_af_c6", 32'(bus.almost_full), 1);
        repeat (4) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("t_ae_c2b", 32'(bus.almost_empty), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("t_ae_c1", 32'(bus.almost_empty), 1);

        cyc(0, 1, 10'h2A1, 0);
        cyc(0, 1, 10'h2A2, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("mr_cnt", 32'(bus.fifo_count), 0);
        chk("mr_valid", 32'(bus.valid), 0);
        chk("mr_udf", 32'(bus.err_underflow), 0);
        chk("mr_empty", 32'(bus.empty), 1);

        cyc(0, 1, 10'h011, 0);
        cyc(0, 1, 10'h022, 0);
        cyc(0, 1, 10'h033, 1);
        cyc(0, 1, 10'h044, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("mx_dout", 32'(bus.data_out), 32'h044);
        cyc(0, 0, 0, 0);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
